instr_encoder: RTL and testbench

Encoder side of the ALU decode interface. Accepts decoded micro-ops (ALU op, ssel, imm, register IDs) over a valid/ready handshake, packs each into a 32-bit MIPS R/I-type word, buffers it in a small FIFO, and streams the words into instruction memory at consecutive byte addresses. It sits between the test/program generator and the instruction memory write port. Encoding each decoder output back to a word must reproduce the original fields.

---
 rtl/mips_pkg.sv | 88 ++++++++
 rtl/instr_encoder_if.sv | 38 +++
 rtl/sync_fifo.sv | 66 ++++++
 rtl/instr_encoder.sv | 117 +++++++++++
 tb/tb_instr_encoder.sv | 353 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// MIPS field widths, ALU op codes, funct/opcode constants and the micro-op
// packer shared by the ALU decoder and the instruction encoder.
package mips_pkg;

  localparam int OP_W    = 4;
  localparam int REG_W   = 5;
  localparam int OPC_W   = 6;
  localparam int FUNCT_W = 6;
  localparam int IMM_W   = 16;
  localparam int WORD_W  = 32;

  // ALU control codes as produced by the decoder
  localparam logic [OP_W-1:0] ALU_AND = 4'b0000;
  localparam logic [OP_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [OP_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [OP_W-1:0] ALU_SUB = 4'b0110;
  localparam logic [OP_W-1:0] ALU_SLT = 4'b0111;
  localparam logic [OP_W-1:0] ALU_NOR = 4'b1100;

  // R-type funct field
  localparam logic [FUNCT_W-1:0] FUNCT_ADD = 6'h20;
  localparam logic [FUNCT_W-1:0] FUNCT_SUB = 6'h22;
  localparam logic [FUNCT_W-1:0] FUNCT_AND = 6'h24;
  localparam logic [FUNCT_W-1:0] FUNCT_OR  = 6'h25;
  localparam logic [FUNCT_W-1:0] FUNCT_NOR = 6'h27;
  localparam logic [FUNCT_W-1:0] FUNCT_SLT = 6'h2A;

  // Primary opcodes
  localparam logic [OPC_W-1:0] OPC_RTYPE = 6'h00;
  localparam logic [OPC_W-1:0] OPC_ADDI  = 6'h08;
  localparam logic [OPC_W-1:0] OPC_SLTI  = 6'h0A;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } enc_state_e;

  typedef struct packed {
    logic              legal;
    logic [WORD_W-1:0] word;
  } enc_result_t;

  // Pack one micro-op into an R- or I-type word; legal=0 marks a request
  // that has no encoding (unknown op, unsupported immediate op, or an
  // immediate that does not fit in 16 signed bits).
  function automatic enc_result_t encode_uop(
    input logic [OP_W-1:0]   op,
    input logic              ssel,
    input logic [WORD_W-1:0] imm,
    input logic [REG_W-1:0]  rs1,
    input logic [REG_W-1:0]  rs2,
    input logic [REG_W-1:0]  rdst
  );
    enc_result_t         res;
    logic [FUNCT_W-1:0]  funct;
    logic [OPC_W-1:0]    opc;
    logic                imm_fits;
    res.legal = 1'b0;
    res.word  = '0;
    funct     = FUNCT_ADD;
    opc       = OPC_ADDI;
    imm_fits  = (imm[WORD_W-1:IMM_W] == {(WORD_W-IMM_W){imm[IMM_W-1]}});
    if (ssel) begin
      res.legal = 1'b1;
      case (op)
        ALU_AND: funct = FUNCT_AND;
        ALU_OR:  funct = FUNCT_OR;
        ALU_ADD: funct = FUNCT_ADD;
        ALU_SUB: funct = FUNCT_SUB;
        ALU_NOR: funct = FUNCT_NOR;
        ALU_SLT: funct = FUNCT_SLT;
        default: res.legal = 1'b0;
      endcase
      res.word = {OPC_RTYPE, rs1, rs2, rdst, 5'h00, funct};
    end else begin
      res.legal = imm_fits;
      case (op)
        ALU_ADD: opc = OPC_ADDI;
        ALU_SLT: opc = OPC_SLTI;
        default: res.legal = 1'b0;
      endcase
      res.word = {opc, rs1, rdst, imm[IMM_W-1:0]};
    end
    return res;
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Control, micro-op handshake and memory write port of the instruction encoder.
// master = program generator / memory side, slave = encoder.
interface instr_encoder_if #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 10
);
  logic              start;
  logic [AWIDTH-1:0] base_addr;
  logic              stop;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_op;
  logic              in_ssel;
  logic [DWIDTH-1:0] in_imm;
  logic [4:0]        in_rs1_id;
  logic [4:0]        in_rs2_id;
  logic [4:0]        in_rdst_id;
  logic              mem_we;
  logic [AWIDTH-1:0] mem_addr;
  logic [DWIDTH-1:0] mem_wdata;
  logic              mem_ready;
  logic              busy;
  logic              done;
  logic              err;
  logic [7:0]        err_cnt;

  modport master (
    output start, base_addr, stop, in_valid, in_op, in_ssel, in_imm,
           in_rs1_id, in_rs2_id, in_rdst_id, mem_ready,
    input  in_ready, mem_we, mem_addr, mem_wdata, busy, done, err, err_cnt
  );

  modport slave (
    input  start, base_addr, stop, in_valid, in_op, in_ssel, in_imm,
           in_rs1_id, in_rs2_id, in_rdst_id, mem_ready,
    output in_ready, mem_we, mem_addr, mem_wdata, busy, done, err, err_cnt
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with full/empty flags and occupancy count.
module sync_fifo #(
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [DWIDTH-1:0]        i_data,
  input  logic                     i_pop,
  output logic [DWIDTH-1:0]        o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   FULL_CNT = DEPTH[PTR_W:0];
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [DWIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W:0]    r_count;
  logic              w_push_ok;
  logic              w_pop_ok;

  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;
  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign o_data    = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  // Storage: write at tail; cleared on reset so no stale word survives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers wrap naturally (DEPTH is a power of two); count tracks occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/instr_encoder.sv
// Packs decoded micro-ops into MIPS words, queues them and streams them to
// instruction memory at consecutive byte addresses.
module instr_encoder
  import mips_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 10,
  parameter int DEPTH  = 4
) (
  input logic            clk,
  input logic            rst_n,
  instr_encoder_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [AWIDTH-1:0] ADDR_STEP = AWIDTH'(4);

  enc_state_e        r_state;
  logic [AWIDTH-1:0] r_addr;
  logic              r_done;
  logic              r_err;
  logic [7:0]        r_err_cnt;

  enc_result_t       w_enc;
  logic              w_full;
  logic              w_empty;
  logic [CNT_W-1:0]  w_count;
  logic [DWIDTH-1:0] w_head;
  logic              w_in_ready;
  logic              w_accept;
  logic              w_push;
  logic              w_mem_we;
  logic              w_pop;
  logic              w_drain_done;

  assign w_enc = encode_uop(bus.in_op, bus.in_ssel, bus.in_imm,
                            bus.in_rs1_id, bus.in_rs2_id, bus.in_rdst_id);

  // Push is refused whenever full, even if a pop happens in the same cycle.
  assign w_in_ready   = (r_state == ST_RUN) && !w_full;
  assign w_accept     = bus.in_valid && w_in_ready;
  assign w_push       = w_accept && w_enc.legal;
  assign w_mem_we     = !w_empty && (r_state != ST_IDLE);
  assign w_pop        = w_mem_we && bus.mem_ready;
  // Draining finishes when the queue is empty now or the last word leaves now.
  assign w_drain_done = w_empty || (w_pop && (w_count == CNT_ONE));

  sync_fifo #(
    .DWIDTH (DWIDTH),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (w_enc.word),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Control FSM with write address, done pulse and error bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_addr    <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_err_cnt <= 8'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_state   <= ST_RUN;
            r_addr    <= bus.base_addr;
            r_err     <= 1'b0;
            r_err_cnt <= 8'd0;
          end
        end
        ST_RUN: begin
          if (bus.stop) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_drain_done) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
      if (w_pop) begin
        r_addr <= r_addr + ADDR_STEP;
      end
      if (w_accept && !w_enc.legal) begin
        r_err <= 1'b1;
        if (r_err_cnt != 8'hFF) begin
          r_err_cnt <= r_err_cnt + 8'd1;
        end
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.mem_we    = w_mem_we;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = w_mem_we ? w_head : '0;
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.done      = r_done;
  assign bus.err       = r_err;
  assign bus.err_cnt   = r_err_cnt;
endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder with a cycle-level behavioural model.
module tb_instr_encoder;
  logic clk;
  logic rst_n;

  instr_encoder_if #(.DWIDTH(32), .AWIDTH(10)) bus ();

  instr_encoder #(.DWIDTH(32), .AWIDTH(10), .DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [9:0]  a;
    logic [31:0] d;
  } wr_t;
  wr_t wr_log[$];

  // model state: 0 idle, 1 run, 2 drain
  int          m_state = 0;
  logic [31:0] m_q[$];
  int          m_addr = 0;
  bit          m_err = 0;
  int          m_cnt = 0;
  bit          m_done = 0;
  int          n_acc = 0;
  int          cyc = 0;
  int          last_wr_cyc = -1;
  int          done_cyc = -1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference encoding derived directly from the MIPS field layout.
  function automatic bit model_enc(input logic [3:0] op, input bit ssel, input logic [31:0] imm,
                                   input int rs1, input int rs2, input int rd,
                                   output logic [31:0] w);
    int f;
    int opc;
    w = 32'h0;
    if (ssel) begin
      case (op)
        4'b0010: f = 32;
        4'b0110: f = 34;
        4'b0000: f = 36;
        4'b0001: f = 37;
        4'b1100: f = 39;
        4'b0111: f = 42;
        default: return 1'b0;
      endcase
      w = 32'(rs1 * 2097152 + rs2 * 65536 + rd * 2048 + f);
      return 1'b1;
    end
    if ($signed(imm) < -32768 || $signed(imm) > 32767) return 1'b0;
    if (op == 4'b0010) opc = 8;
    else if (op == 4'b0111) opc = 10;
    else return 1'b0;
    w = 32'(opc * 67108864 + rs1 * 2097152 + rd * 65536) + (imm & 32'h0000FFFF);
    return 1'b1;
  endfunction

  // Compare DUT against the model every cycle, then advance the model.
  always @(negedge clk) begin
    bit          exp_we;
    bit          exp_rdy;
    bit          nd;
    logic [31:0] w;
    cyc++;
    if (!rst_n) begin
      m_state = 0;
      m_q.delete();
      m_addr = 0;
      m_err = 0;
      m_cnt = 0;
      m_done = 0;
      chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    end else begin
      exp_we  = (m_state != 0) && (m_q.size() > 0);
      exp_rdy = (m_state == 1) && (m_q.size() < 4);
      chk("busy", 32'(bus.busy), 32'(m_state != 0));
      chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
      chk("mem_we", 32'(bus.mem_we), 32'(exp_we));
      chk("done", 32'(bus.done), 32'(m_done));
      chk("err", 32'(bus.err), 32'(m_err));
      chk("err_cnt", 32'(bus.err_cnt), 32'(m_cnt));
      if (exp_we) begin
        chk("mem_addr", 32'(bus.mem_addr), 32'(m_addr));
        chk("mem_wdata", bus.mem_wdata, m_q[0]);
      end
      if (bus.mem_we && bus.mem_ready) begin
        wr_log.push_back('{a: bus.mem_addr, d: bus.mem_wdata});
        last_wr_cyc = cyc;
      end
      if (bus.done) done_cyc = cyc;
      nd = 0;
      if (exp_we && bus.mem_ready) begin
        void'(m_q.pop_front());
        m_addr = (m_addr + 4) % 1024;
      end
      if (bus.in_valid && exp_rdy) begin
        n_acc++;
        if (model_enc(bus.in_op, bus.in_ssel, bus.in_imm, int'(bus.in_rs1_id),
                      int'(bus.in_rs2_id), int'(bus.in_rdst_id), w)) begin
          m_q.push_back(w);
        end else begin
          m_err = 1;
          if (m_cnt < 255) m_cnt++;
        end
      end
      case (m_state)
        0: if (bus.start) begin
             m_state = 1;
             m_addr = int'(bus.base_addr);
             m_err = 0;
             m_cnt = 0;
           end
        1: if (bus.stop) m_state = 2;
        2: if (m_q.size() == 0) begin
             m_state = 0;
             nd = 1;
           end
        default: m_state = 0;
      endcase
      m_done = nd;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [9:0] base);
    bus.base_addr = base;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic stop_run();
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
  endtask

  task automatic push(input logic [3:0] op, input logic ssel, input logic [31:0] imm,
                      input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd);
    bit acc;
    bit got;
    bus.in_op = op;
    bus.in_ssel = ssel;
    bus.in_imm = imm;
    bus.in_rs1_id = r1;
    bus.in_rs2_id = r2;
    bus.in_rdst_id = rd;
    bus.in_valid = 1'b1;
    got = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      acc = bus.in_ready;
      step();
      if (acc) begin
        got = 1;
        break;
      end
    end
    bus.in_valid = 1'b0;
    total++;
    if (!got) begin
      bad++;
      $display("FAIL push_timeout: got no handshake expected handshake within 100 cycles");
    end
  endtask

  task automatic wait_done();
    bit got;
    got = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.done) begin
        got = 1;
        break;
      end
    end
    step();
    total++;
    if (!got) begin
      bad++;
      $display("FAIL done_timeout: got no done expected done within 200 cycles");
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got time limit expected test end");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_idx;
    int acc0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.base_addr = 10'h000;
    bus.stop = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_op = 4'b0000;
    bus.in_ssel = 1'b0;
    bus.in_imm = 32'h0;
    bus.in_rs1_id = 5'd0;
    bus.in_rs2_id = 5'd0;
    bus.in_rdst_id = 5'd0;
    bus.mem_ready = 1'b1;
    #22;
    chk("reset_in_ready", 32'(bus.in_ready), 32'd0);
    chk("reset_mem_we", 32'(bus.mem_we), 32'd0);
    chk("reset_mem_addr", 32'(bus.mem_addr), 32'h0);
    chk("reset_mem_wdata", bus.mem_wdata, 32'h0);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    chk("reset_err", 32'(bus.err), 32'd0);
    chk("reset_err_cnt", 32'(bus.err_cnt), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // R-type ADD, one-cycle latency to memory
    start_run(10'h010);
    push(4'b0010, 1'b1, 32'h0, 5'd1, 5'd2, 5'd3);
    @(negedge clk);
    chk("first_we", 32'(bus.mem_we), 32'd1);
    chk("first_addr", 32'(bus.mem_addr), 32'h010);
    chk("first_data", bus.mem_wdata, 32'h00221820);
    step();

    // addi / slti
    base_idx = wr_log.size();
    push(4'b0010, 1'b0, 32'hFFFFFFFF, 5'd4, 5'd0, 5'd5);
    push(4'b0111, 1'b0, 32'h00000007, 5'd1, 5'd0, 5'd2);
    repeat (3) step();
    chk("itype_count", 32'(wr_log.size() - base_idx), 32'd2);
    if (wr_log.size() >= base_idx + 2) begin
      chk("addi_addr", 32'(wr_log[base_idx].a), 32'h014);
      chk("addi_data", wr_log[base_idx].d, 32'h2085FFFF);
      chk("slti_addr", 32'(wr_log[base_idx+1].a), 32'h018);
      chk("slti_data", wr_log[base_idx+1].d, 32'h28220007);
    end

    // illegal requests
    base_idx = wr_log.size();
    push(4'b1111, 1'b1, 32'h0, 5'd1, 5'd2, 5'd3);
    push(4'b0110, 1'b0, 32'h5, 5'd1, 5'd2, 5'd3);
    push(4'b0010, 1'b0, 32'h00010000, 5'd1, 5'd2, 5'd3);
    repeat (3) step();
    chk("illegal_err", 32'(bus.err), 32'd1);
    chk("illegal_cnt", 32'(bus.err_cnt), 32'd3);
    chk("illegal_nowrite", 32'(wr_log.size() - base_idx), 32'd0);
    stop_run();
    wait_done();

    // back-pressure: memory stalled, six pushes
    bus.mem_ready = 1'b0;
    start_run(10'h100);
    chk("start_clears_err", 32'(bus.err), 32'd0);
    chk("start_clears_cnt", 32'(bus.err_cnt), 32'd0);
    base_idx = wr_log.size();
    acc0 = n_acc;
    fork
      begin
        push(4'b0000, 1'b1, 32'h0, 5'd7, 5'd8, 5'd9);
        push(4'b0001, 1'b1, 32'h0, 5'd10, 5'd11, 5'd12);
        push(4'b1100, 1'b1, 32'h0, 5'd13, 5'd14, 5'd15);
        push(4'b0111, 1'b1, 32'h0, 5'd16, 5'd17, 5'd18);
        push(4'b0110, 1'b1, 32'h0, 5'd19, 5'd20, 5'd21);
        push(4'b0111, 1'b0, 32'hFFFFFFFE, 5'd22, 5'd0, 5'd23);
      end
      begin
        repeat (10) @(negedge clk);
        chk("stall_accepted", 32'(n_acc - acc0), 32'd4);
        chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
        chk("stall_we", 32'(bus.mem_we), 32'd1);
        chk("stall_addr", 32'(bus.mem_addr), 32'h100);
        chk("stall_data", bus.mem_wdata, 32'h00E84824);
        step();
        bus.mem_ready = 1'b1;
      end
    join
    repeat (8) step();
    chk("stall_written", 32'(wr_log.size() - base_idx), 32'd6);
    if (wr_log.size() >= base_idx + 6) begin
      chk("stall_last_addr", 32'(wr_log[base_idx+5].a), 32'h114);
      chk("stall_last_data", wr_log[base_idx+5].d, 32'h2AD7FFFE);
    end
    stop_run();
    wait_done();

    // address wrap, stop together with a handshake
    start_run(10'h3FC);
    base_idx = wr_log.size();
    push(4'b0001, 1'b1, 32'h0, 5'd0, 5'd0, 5'd0);
    bus.stop = 1'b1;
    push(4'b0010, 1'b0, 32'h00000005, 5'd0, 5'd0, 5'd1);
    bus.stop = 1'b0;
    wait_done();
    chk("wrap_count", 32'(wr_log.size() - base_idx), 32'd2);
    if (wr_log.size() >= base_idx + 2) begin
      chk("wrap_addr0", 32'(wr_log[base_idx].a), 32'h3FC);
      chk("wrap_data0", wr_log[base_idx].d, 32'h00000025);
      chk("wrap_addr1", 32'(wr_log[base_idx+1].a), 32'h000);
      chk("wrap_data1", wr_log[base_idx+1].d, 32'h20010005);
    end
    chk("done_timing", 32'(done_cyc - last_wr_cyc), 32'd1);
    chk("idle_after_done", 32'(bus.busy), 32'd0);

    // reset with queued words
    bus.mem_ready = 1'b0;
    start_run(10'h000);
    push(4'b0010, 1'b1, 32'h0, 5'd1, 5'd1, 5'd1);
    push(4'b0010, 1'b1, 32'h0, 5'd2, 5'd2, 5'd2);
    push(4'b0010, 1'b1, 32'h0, 5'd3, 5'd3, 5'd3);
    chk("pre_reset_we", 32'(bus.mem_we), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_reset_we", 32'(bus.mem_we), 32'd0);
    chk("mid_reset_busy", 32'(bus.busy), 32'd0);
    step();
    rst_n = 1'b1;
    bus.mem_ready = 1'b1;
    base_idx = wr_log.size();
    repeat (5) step();
    chk("post_reset_nowrite", 32'(wr_log.size() - base_idx), 32'd0);
    chk("post_reset_busy", 32'(bus.busy), 32'd0);
    chk("post_reset_addr", 32'(bus.mem_addr), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
